dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL use parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words, a power of two, at least 4.
REQ-002 The block SHALL use parameter RD_LATENCY, default 1, meaning the number of array read cycles, legal range 1..4.
REQ-003 The block SHALL use parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have these request ports:
- req_valid, input, 1 bit: request present.
- req_ready, output, 1 bit: block can accept a request.
- req_we, input, 1 bit: 1 = store, 0 = load.
- req_addr, input, XLEN bits: byte address.
- req_wdata, input, XLEN bits: store data, right-aligned.
- req_op, input, mem_op_e: access size and sign.
REQ-007 The block SHALL have these response ports:
- rsp_valid, output, 1 bit: response present.
- rsp_ready, input, 1 bit: consumer accepts the response.
- rsp_rdata, output, XLEN bits: load data after extension; 0 for stores and errors.
- rsp_err, output, 1 bit: access fault.

Function
REQ-008 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; only one transaction SHALL be outstanding at a time.
REQ-009 The FSM SHALL have states IDLE, READ, and RESP, with these transitions:
- IDLE to READ on an accepted, fault-free load.
- IDLE to RESP on an accepted store or faulted request.
- READ to RESP when the latency counter reaches RD_LATENCY-1.
- RESP to IDLE when rsp_ready is 1.
REQ-010 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-011 Response timing SHALL be as follows, with T the accept edge and rsp_ready held at 1:
- Stores and faults: rsp_valid first high after edge T+1.
- Loads: rsp_valid first high after edge T+1+RD_LATENCY.
REQ-012 rsp_valid, rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-013 A request SHALL fault (rsp_err=1, no array write, rsp_rdata=0) in any of these cases:
- MEM_HALF or MEM_HALF_U with addr[0]=1.
- MEM_WORD with addr[1:0]!=0.
- (addr-BASE_ADDR) >= 4*DEPTH_WORDS, with unsigned compare.
- req_we=1 with MEM_BYTE_U or MEM_HALF_U.
REQ-014 Stores SHALL write the array on the accept edge using per-byte enables, little-endian:
- Byte: enable bit = addr[1:0], data = wdata[7:0].
- Half: enables 2'b11 shifted by addr[1], data = wdata[15:0].
- Word: all four enables.
Bytes not enabled SHALL be left unchanged.
REQ-015 Loads SHALL read the full word and extract the addressed lane as follows:
- LB/LH: sign-extend to XLEN.
- LBU/LHU: zero-extend to XLEN.
- LW: pass the word through.
The extracted value SHALL be registered into rsp_rdata on entry to RESP.
REQ-016 A load issued after a store to the same byte SHALL return the stored value, with no bypass needed because of the single-outstanding rule.
REQ-017 The word index SHALL be (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; upper bits are used only for the range check.
REQ-018 Accepting a new request in the same cycle a response handshakes SHALL NOT occur; IDLE is always visited for at least one cycle.

Reset
REQ-019 On a rising edge with rst_n=0, the block SHALL enter IDLE, clear the latency counter, and drive rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-020 req_ready SHALL read 0 while rst_n=0 and 1 on the first cycle after release.
REQ-021 Reset during READ or RESP SHALL discard the pending response; no response SHALL be issued for it.
REQ-022 A store presented on an edge with rst_n=0 SHALL NOT write; array contents SHALL NOT be cleared by reset.

Structure
REQ-023 XLEN and mem_op_e SHALL come from riscv_pkg; dmem_state_e (IDLE/READ/RESP) SHALL be added to riscv_pkg.
REQ-024 The array SHALL be a sub-module dmem_bram that infers block RAM:
- Parameters DEPTH_WORDS and RD_LATENCY.
- Ports: byte-enable write port, and synchronous read port with a RD_LATENCY-deep output pipeline.
REQ-025 Fault detection, byte-enable generation and load extraction SHALL be combinational logic in dmem_ctrl.

Verification
REQ-026 SW 0xDEADBEEF at 0x10, then LW 0x10 with RD_LATENCY=3 -> store response at T+1 with rsp_err=0; load rsp_rdata=0xDEADBEEF, rsp_valid first high after edge T+4.
REQ-027 SB 0x80 at 0x21, then LB 0x21 and LBU 0x21 -> rsp_rdata=0xFFFFFF80, then 0x00000080; LW 0x20 shows only byte 1 changed.
REQ-028 LH at 0x13, SW at 0x22, and LW at 4*DEPTH_WORDS -> each gives rsp_err=1 and rsp_rdata=0; a following LW of the original word shows it unchanged.
REQ-029 LW accepted, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rsp_ready then 1 for one cycle -> IDLE, req_ready=1 the next cycle.
REQ-030 rst_n=0 during READ with RD_LATENCY=4 -> no response issued; req_ready=1 after release; earlier stored data still reads back correctly.
REQ-031 SH 0xA5A5 at BASE_ADDR+2 with BASE_ADDR=0x8000_0000 -> LHU returns 0x0000A5A5 and LH returns 0xFFFFA5A5.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width, memory access encodings, and the
// data-memory controller state machine.
package riscv_pkg;

  localparam int XLEN = 32;

  // Encodings follow the load/store funct3 field.
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'b000,
    MEM_HALF   = 3'b001,
    MEM_WORD   = 3'b010,
    MEM_BYTE_U = 3'b100,
    MEM_HALF_U = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_bram.sv
// Word-organised data RAM with per-byte write enables and a synchronous
// read port followed by a RD_LATENCY-deep output pipeline.
module dmem_bram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_p [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage 0 is the array read itself; later stages only delay it.
  always_ff @(posedge clk) begin
    if (re) rdata_p[0] <= mem[addr];
    for (int i = 1; i < RD_LATENCY; i++) begin
      rdata_p[i] <= rdata_p[i-1];
    end
  end

  assign rdata = rdata_p[RD_LATENCY-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: request/response handshake,
// fault detection, byte-lane write enables and load extension.
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter int              RD_LATENCY  = 1,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  mem_op_e         req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int              AW   = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] SPAN = XLEN'(4 * DEPTH_WORDS);

  dmem_state_e     state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;
  mem_op_e         op_p0;
  logic [1:0]      lane_p0;

  logic [XLEN-1:0] offs;
  logic            accept, misalign, oob, bad_store, fault;
  logic [3:0]      be;
  logic [31:0]     wdata_lane;
  logic [31:0]     ram_rdata;
  logic            ram_we, ram_re;

  function automatic logic [XLEN-1:0] extract(input mem_op_e op, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      MEM_BYTE:   extract = {{24{b[7]}}, b};
      MEM_BYTE_U: extract = {24'h0, b};
      MEM_HALF:   extract = {{16{h[15]}}, h};
      MEM_HALF_U: extract = {16'h0, h};
      MEM_WORD:   extract = word;
      default:    extract = '0;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign offs      = req_addr - BASE_ADDR;

  // Undefined op encodings are treated as misaligned so they always fault.
  always_comb begin
    misalign = 1'b0;
    case (req_op)
      MEM_BYTE, MEM_BYTE_U: misalign = 1'b0;
      MEM_HALF, MEM_HALF_U: misalign = req_addr[0];
      MEM_WORD:             misalign = |req_addr[1:0];
      default:              misalign = 1'b1;
    endcase
  end

  assign oob       = offs >= SPAN;
  assign bad_store = req_we && ((req_op == MEM_BYTE_U) || (req_op == MEM_HALF_U));
  assign fault     = misalign || oob || bad_store;

  always_comb begin
    be         = 4'b0000;
    wdata_lane = req_wdata;
    case (req_op)
      MEM_BYTE: begin
        be         = 4'b0001 << req_addr[1:0];
        wdata_lane = {4{req_wdata[7:0]}};
      end
      MEM_HALF: begin
        be         = 4'b0011 << {req_addr[1], 1'b0};
        wdata_lane = {2{req_wdata[15:0]}};
      end
      MEM_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
  end

  assign ram_we = accept && req_we && !fault;
  assign ram_re = accept && !req_we && !fault;

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .RD_LATENCY (RD_LATENCY)
  ) u_bram (
    .clk  (clk),
    .we   (ram_we),
    .be   (be),
    .re   (ram_re),
    .addr (offs[AW+1:2]),
    .wdata(wdata_lane),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (accept) state_d = (req_we || fault) ? RESP : READ;
      end
      READ: begin
        if (cnt_q == 2'(RD_LATENCY - 1)) state_d = RESP;
        else                              cnt_d   = cnt_q + 2'd1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture of the accepted request: lane and size steer the load extraction.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= req_op;
      lane_p0 <= req_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && accept) begin
        err_q   <= fault;
        rdata_q <= '0;
      end else if (state_q == READ && state_d == RESP) begin
        rdata_q <= extract(op_p0, lane_p0, ram_rdata);
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: two instances (RD_LATENCY=3 at base 0, and
// RD_LATENCY=4 at base 0x8000_0000) driven by directed vectors.
module tb_dmem_ctrl;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  mem_op_e     req_op    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(1024), .RD_LATENCY(3), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_op(req_op[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(16), .RD_LATENCY(4), .BASE_ADDR(32'h8000_0000)) dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_op(req_op[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever a response handshakes.
  always @(negedge clk) begin
    #1;
    for (int s = 0; s < 2; s++) begin
      if (rst_n[s] && rsp_valid[s] && rsp_ready[s]) begin
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got rdata 0x%08h err %0b, expected none",
                   s, rsp_rdata[s], rsp_err[s]);
        end else begin
          if (s == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk($sformatf("%s_rdata", mon_e.name), rsp_rdata[s], mon_e.rdata);
          chk($sformatf("%s_err", mon_e.name), 32'(rsp_err[s]), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic do_req(input int s, input logic we, input mem_op_e op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int hold, input string name);
    exp_t        e;
    int          n;
    bit          seen;
    logic [31:0] snap_rd;
    logic        snap_err;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.name  = name;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_op[s]    = op;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    chk($sformatf("%s_req_ready", name), 32'(req_ready[s]), 32'd1);
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 32) begin
      @(negedge clk);
      n++;
      req_valid[s] = 1'b0;
      if (rsp_valid[s]) seen = 1'b1;
    end
    chk($sformatf("%s_latency", name), 32'(n), 32'(exp_lat));
    if (seen) begin
      snap_rd  = rsp_rdata[s];
      snap_err = rsp_err[s];
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk($sformatf("%s_hold_valid", name), 32'(rsp_valid[s]), 32'd1);
        chk($sformatf("%s_hold_rdata", name), rsp_rdata[s], snap_rd);
        chk($sformatf("%s_hold_err", name), 32'(rsp_err[s]), 32'(snap_err));
        chk($sformatf("%s_hold_req_ready", name), 32'(req_ready[s]), 32'd0);
      end
      rsp_ready[s] = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_idle_req_ready", name), 32'(req_ready[s]), 32'd1);
      chk($sformatf("%s_idle_rsp_valid", name), 32'(rsp_valid[s]), 32'd0);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s]     = 1'b0;
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
      req_op[s]    = MEM_WORD;
      rsp_ready[s] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_req_ready%0d", s), 32'(req_ready[s]), 32'd0);
      chk($sformatf("rst_rsp_valid%0d", s), 32'(rsp_valid[s]), 32'd0);
      chk($sformatf("rst_rsp_err%0d", s), 32'(rsp_err[s]), 32'd0);
      chk($sformatf("rst_rsp_rdata%0d", s), rsp_rdata[s], 32'd0);
      rst_n[s] = 1'b1;
    end
    @(negedge clk);
    chk("rel_req_ready0", 32'(req_ready[0]), 32'd1);
    chk("rel_req_ready1", 32'(req_ready[1]), 32'd1);

    // Instance A: RD_LATENCY=3 -> load handshake 4 edges after accept.
    do_req(0, 1, MEM_WORD,   32'h10,   32'hDEADBEEF, 32'h0,        0, 1, 0, "sw_10");
    do_req(0, 0, MEM_WORD,   32'h10,   32'h0,        32'hDEADBEEF, 0, 4, 0, "lw_10");
    do_req(0, 1, MEM_WORD,   32'h20,   32'h11223344, 32'h0,        0, 1, 0, "sw_20");
    do_req(0, 1, MEM_BYTE,   32'h21,   32'h12345680, 32'h0,        0, 1, 0, "sb_21");
    do_req(0, 0, MEM_BYTE,   32'h21,   32'h0,        32'hFFFFFF80, 0, 4, 0, "lb_21");
    do_req(0, 0, MEM_BYTE_U, 32'h21,   32'h0,        32'h00000080, 0, 4, 0, "lbu_21");
    do_req(0, 0, MEM_WORD,   32'h20,   32'h0,        32'h11228044, 0, 4, 0, "lw_20");
    do_req(0, 0, MEM_HALF_U, 32'h20,   32'h0,        32'h00008044, 0, 4, 0, "lhu_20");
    do_req(0, 0, MEM_HALF,   32'h22,   32'h0,        32'h00001122, 0, 4, 0, "lh_22");
    do_req(0, 0, MEM_HALF,   32'h13,   32'h0,        32'h0,        1, 1, 0, "lh_13_fault");
    do_req(0, 1, MEM_WORD,   32'h22,   32'hCAFEF00D, 32'h0,        1, 1, 0, "sw_22_fault");
    do_req(0, 0, MEM_WORD,   32'h1000, 32'h0,        32'h0,        1, 1, 0, "lw_oob_fault");
    do_req(0, 1, MEM_BYTE_U, 32'h10,   32'h0,        32'h0,        1, 1, 0, "sbu_fault");
    do_req(0, 0, MEM_WORD,   32'h10,   32'h0,        32'hDEADBEEF, 0, 4, 0, "lw_10_after");
    do_req(0, 0, MEM_WORD,   32'h20,   32'h0,        32'h11228044, 0, 4, 0, "lw_20_after");
    rsp_ready[0] = 1'b0;
    do_req(0, 0, MEM_WORD,   32'h10,   32'h0,        32'hDEADBEEF, 0, 4, 5, "lw_hold");

    // Instance B: base 0x8000_0000, 16 words, RD_LATENCY=4.
    do_req(1, 1, MEM_HALF,   32'h8000_0002, 32'h1234A5A5, 32'h0,        0, 1, 0, "sh_b2");
    do_req(1, 0, MEM_HALF_U, 32'h8000_0002, 32'h0,        32'h0000A5A5, 0, 5, 0, "lhu_b2");
    do_req(1, 0, MEM_HALF,   32'h8000_0002, 32'h0,        32'hFFFFA5A5, 0, 5, 0, "lh_b2");
    do_req(1, 1, MEM_WORD,   32'h8000_0010, 32'h0BADF00D, 32'h0,        0, 1, 0, "sw_b10");

    // Load interrupted by reset in READ, with a store held on req while in reset.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_op[1]    = MEM_WORD;
    req_addr[1]  = 32'h8000_0010;
    @(posedge clk);
    @(negedge clk);
    chk("rdrst_in_read_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    rst_n[1]     = 1'b0;
    req_we[1]    = 1'b1;
    req_wdata[1] = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("rdrst_req_ready_low", 32'(req_ready[1]), 32'd0);
      chk("rdrst_rsp_valid_low", 32'(rsp_valid[1]), 32'd0);
    end
    rst_n[1]     = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rdrst_release_req_ready", 32'(req_ready[1]), 32'd1);
    repeat (8) begin
      @(negedge clk);
      chk("rdrst_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    do_req(1, 0, MEM_WORD,   32'h8000_0010, 32'h0, 32'h0BADF00D, 0, 5, 0, "lw_b10_after_rst");
    do_req(1, 0, MEM_HALF_U, 32'h8000_0002, 32'h0, 32'h0000A5A5, 0, 5, 0, "lhu_b2_after_rst");
    do_req(1, 0, MEM_WORD,   32'h7FFF_FFFC, 32'h0, 32'h0,        1, 1, 0, "lw_below_base");
    do_req(1, 0, MEM_WORD,   32'h8000_0040, 32'h0, 32'h0,        1, 1, 0, "lw_above_top");

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
